// File: rtl/s420_sweep_ctrl.sv
// Sweep sequencer for one s420 counter/comparator: loads the compare pattern,
// issues a programmed number of P_0 pulses, then counts Z hits and records the first one.
module s420_sweep_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned C_W       = 17,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MODE,
    input  logic [CNT_W-1:0] RUN_LEN,
    input  logic [C_W-1:0]   C_PAT,
    input  logic             Z_IN,
    output logic             P0_OUT,
    output logic [C_W-1:0]   C_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] Z_CNT,
    output logic [CNT_W-1:0] FIRST_HIT,
    output logic             HIT_VALID
);

    localparam int unsigned     DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             p0_q, p0_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] zcnt_q, zcnt_d;
    logic [CNT_W-1:0] fh_q, fh_d;
    logic             hv_q, hv_d;
    logic             sample_z;

    // State and registered outputs
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            p0_q    <= 1'b0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zcnt_q  <= '0;
            fh_q    <= '0;
            hv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            p0_q    <= p0_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zcnt_q  <= zcnt_d;
            fh_q    <= fh_d;
            hv_q    <= hv_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        len_d    = len_q;
        hi_d     = hi_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        p0_d     = p0_q;
        c_d      = c_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zcnt_d   = zcnt_q;
        fh_d     = fh_q;
        hv_d     = hv_q;
        sample_z = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    mode_d  = MODE;
                    len_d   = RUN_LEN;
                    c_d     = C_PAT;
                    zcnt_d  = '0;
                    fh_d    = '0;
                    hv_d    = 1'b0;
                    idx_d   = '0;
                    hi_d    = '0;
                    drain_d = '0;
                    busy_d  = 1'b1;
                    if (RUN_LEN == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                    p0_d    = 1'b1;
                    hi_d    = CNT_W'(1);
                end
            end
            ST_RUN: begin
                sample_z = 1'b1;
                if (ABORT) begin
                    state_d = ST_IDLE;
                    p0_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (p0_q && (hi_q == len_q)) begin
                    state_d = ST_DRAIN;
                    p0_d    = 1'b0;
                    drain_d = '0;
                end else if (mode_q && p0_q) begin
                    p0_d = 1'b0;
                end else begin
                    p0_d = 1'b1;
                    hi_d = hi_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                sample_z = 1'b1;
                if (ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                p0_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Z hit accounting over RUN and DRAIN cycles, both counters saturating
        if (sample_z) begin
            if (Z_IN) begin
                if (zcnt_q != CNT_MAX) begin
                    zcnt_d = zcnt_q + CNT_W'(1);
                end
                if (!hv_q) begin
                    fh_d = idx_q;
                    hv_d = 1'b1;
                end
            end
            if (idx_q != CNT_MAX) begin
                idx_d = idx_q + CNT_W'(1);
            end
        end
    end

    assign P0_OUT    = p0_q;
    assign C_OUT     = c_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign Z_CNT     = zcnt_q;
    assign FIRST_HIT = fh_q;
    assign HIT_VALID = hv_q;

endmodule

// File: tb/tb_s420_sweep_ctrl.sv
// Bench for s420_sweep_ctrl: table of whole sweeps checked cycle by cycle through
// an expected-output queue, plus hand sequences for abort, held START and async reset.
module tb_s420_sweep_ctrl;

    logic        CK;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic        MODE;
    logic [15:0] RUN_LEN;
    logic [16:0] C_PAT;
    logic        Z_IN;
    logic        P0_OUT;
    logic [16:0] C_OUT;
    logic        BUSY;
    logic        DONE;
    logic [15:0] Z_CNT;
    logic [15:0] FIRST_HIT;
    logic        HIT_VALID;

    int tests = 0;
    int fails = 0;

    s420_sweep_ctrl dut (
        .CK        (CK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .MODE      (MODE),
        .RUN_LEN   (RUN_LEN),
        .C_PAT     (C_PAT),
        .Z_IN      (Z_IN),
        .P0_OUT    (P0_OUT),
        .C_OUT     (C_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .Z_CNT     (Z_CNT),
        .FIRST_HIT (FIRST_HIT),
        .HIT_VALID (HIT_VALID)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // zmask bit i = Z_IN in RUN/DRAIN cycle index i; bit 31 = Z_IN during the cycle after accept.
    // p0_exp bit k = P0_OUT after edge k, edge 0 being the accept edge.
    typedef struct {
        logic        mode;
        logic [15:0] len;
        logic [16:0] pat;
        logic [31:0] zmask;
        logic [31:0] p0_exp;
        int          done_edge;
        logic [15:0] zc;
        logic [15:0] fh;
        logic        hv;
    } vec_t;

    typedef struct {
        logic        p0;
        logic        done;
        logic        busy;
        logic [16:0] c;
    } obs_t;

    vec_t vecs[7];
    obs_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        obs_t e;
        START   = 1'b1;
        MODE    = v.mode;
        RUN_LEN = v.len;
        C_PAT   = v.pat;
        Z_IN    = 1'b0;
        for (int k = 0; k <= v.done_edge + 2; k++) begin
            e.p0   = v.p0_exp[k];
            e.done = (k == v.done_edge);
            e.busy = (k <= v.done_edge);
            e.c    = v.pat;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d edge%0d {p0,done,busy,c}", n, k),
                32'({P0_OUT, DONE, BUSY, C_OUT}), 32'({e.p0, e.done, e.busy, e.c}));
            START   = 1'b0;
            C_PAT   = 17'($urandom);
            MODE    = 1'($urandom);
            RUN_LEN = 16'($urandom);
            Z_IN    = (k == 0) ? v.zmask[31] : v.zmask[k-1];
        end
        Z_IN = 1'b0;
        chk($sformatf("vec%0d z_cnt", n), 32'(Z_CNT), 32'(v.zc));
        chk($sformatf("vec%0d first_hit", n), 32'(FIRST_HIT), 32'(v.fh));
        chk($sformatf("vec%0d hit_valid", n), 32'(HIT_VALID), 32'(v.hv));
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (DONE) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   p0_hi;
        int   done_n;
        int   busy_lo;
        logic done_seen;

        vecs[0] = '{mode:1'b0, len:16'd4, pat:17'h1_2345, zmask:32'h0, p0_exp:32'h1E,
                    done_edge:7, zc:16'd0, fh:16'd0, hv:1'b0};
        vecs[1] = '{mode:1'b1, len:16'd3, pat:17'h0_0F0F, zmask:32'h0, p0_exp:32'h2A,
                    done_edge:8, zc:16'd0, fh:16'd0, hv:1'b0};
        vecs[2] = '{mode:1'b0, len:16'd4, pat:17'h1_FFFF, zmask:32'h14, p0_exp:32'h1E,
                    done_edge:7, zc:16'd2, fh:16'd2, hv:1'b1};
        vecs[3] = '{mode:1'b0, len:16'd0, pat:17'h0_A5A5, zmask:32'hFFFF_FFFF, p0_exp:32'h0,
                    done_edge:0, zc:16'd0, fh:16'd0, hv:1'b0};
        vecs[4] = '{mode:1'b1, len:16'd1, pat:17'h1_0001, zmask:32'hFFFF_FFFF, p0_exp:32'h2,
                    done_edge:4, zc:16'd3, fh:16'd0, hv:1'b1};
        vecs[5] = '{mode:1'b0, len:16'd2, pat:17'h0_1234, zmask:32'h8, p0_exp:32'h6,
                    done_edge:5, zc:16'd1, fh:16'd3, hv:1'b1};
        vecs[6] = '{mode:1'b1, len:16'd2, pat:17'h1_8000, zmask:32'h20, p0_exp:32'hA,
                    done_edge:6, zc:16'd0, fh:16'd0, hv:1'b0};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; MODE = 1'b0;
        RUN_LEN = '0; C_PAT = '0; Z_IN = 1'b0;
        tick();
        tick();
        chk("reset ctl {p0,busy,done,hv}", 32'({P0_OUT, BUSY, DONE, HIT_VALID}), 32'(0));
        chk("reset c_out", 32'(C_OUT), 32'(0));
        chk("reset {z_cnt,first_hit}", {Z_CNT, FIRST_HIT}, 32'(0));
        RST = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // ABORT together with START in IDLE: nothing starts
        START = 1'b1; ABORT = 1'b1; RUN_LEN = 16'd3; C_PAT = 17'h0_7777;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("abort+start idle busy", 32'(BUSY), 32'(0));
        chk("abort+start idle c_out held", 32'(C_OUT), 32'(17'h1_8000));
        tick();

        // ABORT in the second RUN cycle of a 10-cycle sweep
        START = 1'b1; MODE = 1'b0; RUN_LEN = 16'd10; C_PAT = 17'h0_ABCD;
        tick();
        START = 1'b0;
        tick();
        chk("abort run1 p0", 32'(P0_OUT), 32'(1));
        Z_IN = 1'b1;
        tick();
        chk("abort run2 p0", 32'(P0_OUT), 32'(1));
        Z_IN = 1'b0; ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort {p0,busy,done}", 32'({P0_OUT, BUSY, DONE}), 32'(0));
        chk("abort partial z_cnt", 32'(Z_CNT), 32'(1));
        chk("abort partial {hv,first_hit}", 32'({HIT_VALID, FIRST_HIT}), 32'({1'b1, 16'd0}));
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE || P0_OUT) done_seen = 1'b1;
        end
        chk("abort no done/p0 afterwards", 32'(done_seen), 32'(0));
        chk("abort c_out held", 32'(C_OUT), 32'(17'h0_ABCD));
        START = 1'b1; MODE = 1'b0; RUN_LEN = 16'd1; C_PAT = 17'h1_5555;
        tick();
        START = 1'b0;
        chk("restart after abort {busy,c}", 32'({BUSY, C_OUT}), 32'({1'b1, 17'h1_5555}));
        wait_done("restart after abort done");

        // START held through a whole sweep: no second sweep before DONE passes
        START = 1'b1; MODE = 1'b0; RUN_LEN = 16'd2; C_PAT = 17'h0_3C3C;
        p0_hi = 0; done_n = 0; busy_lo = 0;
        for (int k = 0; k <= 5; k++) begin
            tick();
            p0_hi   += int'(P0_OUT);
            done_n  += int'(DONE);
            busy_lo += int'(!BUSY);
        end
        chk("held start p0 high count", 32'(p0_hi), 32'(2));
        chk("held start done count", 32'(done_n), 32'(1));
        chk("held start busy gaps", 32'(busy_lo), 32'(0));
        tick();
        chk("held start busy after done", 32'(BUSY), 32'(0));
        tick();
        chk("held start next accept", 32'(BUSY), 32'(1));
        START = 1'b0;
        wait_done("held start second sweep done");

        // Asynchronous reset in the middle of RUN
        START = 1'b1; MODE = 1'b1; RUN_LEN = 16'd10; C_PAT = 17'h1_2345;
        tick();
        START = 1'b0; Z_IN = 1'b1;
        tick();
        tick();
        tick();
        chk("pre-reset {p0,z_cnt}", 32'({P0_OUT, Z_CNT}), 32'({1'b1, 16'd2}));
        #2;
        RST = 1'b1;
        #1;
        chk("async reset ctl {p0,busy,done,hv}", 32'({P0_OUT, BUSY, DONE, HIT_VALID}), 32'(0));
        chk("async reset c_out", 32'(C_OUT), 32'(0));
        chk("async reset {z_cnt,first_hit}", {Z_CNT, FIRST_HIT}, 32'(0));
        #1;
        RST = 1'b0; Z_IN = 1'b0;
        tick();
        tick();
        chk("post-reset idle {p0,busy}", 32'({P0_OUT, BUSY}), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
